// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the AXI slave memory.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BYTES_PER_BEAT = 4;

  typedef enum logic [1:0] {
    W_Idle = 2'd0,
    W_Data = 2'd1,
    W_Resp = 2'd2
  } w_state_e;

  typedef enum logic {
    R_Idle = 1'b0,
    R_Data = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_s_ram.sv
// Depth x 32 RAM: byte-enabled write port, registered read port (read-before-write).
module axi_s_ram #(
  parameter int unsigned Depth = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [3:0]               wstrb_i,
  input  logic [31:0]              wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset so they survive a bus reset.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_s_mem.sv
// AXI slave backed by on-chip word memory; independent read and write burst FSMs.
module axi_s_mem
  import axi_pkg::*;
#(
  parameter int unsigned          WIDTH_ID  = 1,
  parameter int unsigned          WIDTH_AD  = 32,
  parameter int unsigned          WIDTH_DA  = 32,
  parameter int unsigned          DEPTH     = 1024,
  parameter logic [WIDTH_AD-1:0]  BASE_ADDR = 32'h8000_0000
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [WIDTH_ID-1:0]   S_AXI_AWID,
  input  logic [WIDTH_AD-1:0]   S_AXI_AWADDR,
  input  logic [3:0]            S_AXI_AWLEN,
  input  logic [2:0]            S_AXI_AWSIZE,
  input  logic [1:0]            S_AXI_AWBURST,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [WIDTH_DA-1:0]   S_AXI_WDATA,
  input  logic [WIDTH_DA/8-1:0] S_AXI_WSTRB,
  input  logic                  S_AXI_WLAST,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [WIDTH_ID-1:0]   S_AXI_BID,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [WIDTH_ID-1:0]   S_AXI_ARID,
  input  logic [WIDTH_AD-1:0]   S_AXI_ARADDR,
  input  logic [3:0]            S_AXI_ARLEN,
  input  logic [2:0]            S_AXI_ARSIZE,
  input  logic [1:0]            S_AXI_ARBURST,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [WIDTH_ID-1:0]   S_AXI_RID,
  output logic [WIDTH_DA-1:0]   S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RLAST,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int unsigned         IdxW      = $clog2(DEPTH);
  localparam logic [WIDTH_AD-1:0] SpanBytes = WIDTH_AD'(DEPTH * BYTES_PER_BEAT);

  function automatic logic in_range(logic [WIDTH_AD-1:0] addr);
    return (addr - BASE_ADDR) < SpanBytes;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(logic [WIDTH_AD-1:0] addr);
    return IdxW'((addr - BASE_ADDR) >> 2);
  endfunction

  // WRAP and the reserved encoding both step like INCR.
  function automatic logic [WIDTH_AD-1:0] step_addr(logic [WIDTH_AD-1:0] addr, logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + WIDTH_AD'(BYTES_PER_BEAT);
  endfunction

  // SIZE is ignored: every beat is a full word.
  logic unused_size;
  assign unused_size = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

  logic            ram_we, ram_re;
  logic [IdxW-1:0] ram_waddr, ram_raddr;
  logic [31:0]     ram_rdata;

  // ---------------- write path ----------------
  w_state_e            w_state_q, w_state_d;
  logic [WIDTH_ID-1:0] bid_q, bid_d;
  logic [WIDTH_AD-1:0] waddr_q, waddr_d;
  logic [3:0]          wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [1:0]          wburst_q, wburst_d, bresp_q, bresp_d;
  logic                decerr_q, decerr_d, slverr_q, slverr_d;
  logic                w_hit;

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wburst_d  = wburst_q;
    bresp_d   = bresp_q;
    decerr_d  = decerr_q;
    slverr_d  = slverr_q;
    w_hit     = in_range(waddr_q);
    ram_we    = 1'b0;
    unique case (w_state_q)
      W_Idle: begin
        if (S_AXI_AWVALID) begin
          bid_d     = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR;
          wlen_d    = S_AXI_AWLEN;
          wburst_d  = S_AXI_AWBURST;
          wbeat_d   = 4'd0;
          decerr_d  = 1'b0;
          slverr_d  = 1'b0;
          w_state_d = W_Data;
        end
      end
      W_Data: begin
        if (S_AXI_WVALID) begin
          ram_we = w_hit && S_AXI_ARESETN;
          if (!w_hit) decerr_d = 1'b1;
          if (S_AXI_WLAST != (wbeat_q == wlen_q)) slverr_d = 1'b1;
          if (wbeat_q == wlen_q) begin
            bresp_d   = decerr_d ? RESP_DECERR : (slverr_d ? RESP_SLVERR : RESP_OKAY);
            w_state_d = W_Resp;
          end else begin
            wbeat_d = wbeat_q + 4'd1;
            waddr_d = step_addr(waddr_q, wburst_q);
          end
        end
      end
      W_Resp: begin
        if (S_AXI_BREADY) w_state_d = W_Idle;
      end
      default: w_state_d = W_Idle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_Idle;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wburst_q  <= '0;
      bresp_q   <= RESP_OKAY;
      decerr_q  <= 1'b0;
      slverr_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wburst_q  <= wburst_d;
      bresp_q   <= bresp_d;
      decerr_q  <= decerr_d;
      slverr_q  <= slverr_d;
    end
  end

  assign ram_waddr     = word_idx(waddr_q);
  assign S_AXI_AWREADY = (w_state_q == W_Idle);
  assign S_AXI_WREADY  = (w_state_q == W_Data);
  assign S_AXI_BVALID  = (w_state_q == W_Resp);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = bid_q;

  // ---------------- read path ----------------
  r_state_e            r_state_q, r_state_d;
  logic [WIDTH_ID-1:0] rid_q, rid_d;
  logic [WIDTH_AD-1:0] raddr_q, raddr_d, r_next_addr;
  logic [3:0]          rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [1:0]          rburst_q, rburst_d;
  logic                rlast_q, rlast_d, rdecerr_q, rdecerr_d;

  assign r_next_addr = step_addr(raddr_q, rburst_q);

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rburst_d  = rburst_q;
    rlast_d   = rlast_q;
    rdecerr_d = rdecerr_q;
    ram_re    = 1'b0;
    ram_raddr = '0;
    unique case (r_state_q)
      R_Idle: begin
        if (S_AXI_ARVALID) begin
          rid_d     = S_AXI_ARID;
          raddr_d   = S_AXI_ARADDR;
          rlen_d    = S_AXI_ARLEN;
          rburst_d  = S_AXI_ARBURST;
          rbeat_d   = 4'd0;
          rlast_d   = (S_AXI_ARLEN == 4'd0);
          rdecerr_d = !in_range(S_AXI_ARADDR);
          ram_re    = 1'b1;
          ram_raddr = word_idx(S_AXI_ARADDR);
          r_state_d = R_Data;
        end
      end
      R_Data: begin
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_Idle;
          end else begin
            raddr_d   = r_next_addr;
            rbeat_d   = rbeat_q + 4'd1;
            rlast_d   = (rbeat_d == rlen_q);
            rdecerr_d = !in_range(r_next_addr);
            ram_re    = 1'b1;
            ram_raddr = word_idx(r_next_addr);
          end
        end
      end
      default: r_state_d = R_Idle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_Idle;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rburst_q  <= '0;
      rlast_q   <= 1'b0;
      rdecerr_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rburst_q  <= rburst_d;
      rlast_q   <= rlast_d;
      rdecerr_q <= rdecerr_d;
    end
  end

  // The RAM output only changes on a fetch, so it stays stable across stalls.
  assign S_AXI_ARREADY = (r_state_q == R_Idle);
  assign S_AXI_RVALID  = (r_state_q == R_Data);
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RRESP   = (S_AXI_RVALID && rdecerr_q) ? RESP_DECERR : RESP_OKAY;
  assign S_AXI_RDATA   = (S_AXI_RVALID && !rdecerr_q) ? WIDTH_DA'(ram_rdata) : '0;

  axi_s_ram #(
    .Depth (DEPTH)
  ) u_ram (
    .clk_i   (S_AXI_ACLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wstrb_i (S_AXI_WSTRB),
    .wdata_i (S_AXI_WDATA),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_axi_s_mem.sv
// Directed bench for axi_s_mem: bursts, strobes, stalls, decode errors, WLAST errors, reset.
module tb_axi_s_mem;

  localparam int Tmo = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          last_wait;

  always #5 clk = ~clk;

  axi_s_mem dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWID    (awid),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWLEN   (awlen),
    .S_AXI_AWSIZE  (awsize),
    .S_AXI_AWBURST (awburst),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BID     (bid),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARID    (arid),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARSIZE  (arsize),
    .S_AXI_ARBURST (arburst),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RID     (rid),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic aw_req(input logic id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    for (int n = 0; n < Tmo && !awready; n++) @(negedge clk);
    if (!awready) check_eq("aw_timeout", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int n = 0; n < Tmo && !wready; n++) @(negedge clk);
    if (!wready) check_eq("w_timeout", wready, 1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] exp_resp, input logic exp_id, input int stall);
    for (int n = 0; n < Tmo && !bvalid; n++) @(negedge clk);
    if (!bvalid) check_eq("b_timeout", bvalid, 1);
    for (int n = 0; n < stall; n++) begin
      check_eq("b_hold_valid", bvalid, 1);
      check_eq("b_hold_resp", bresp, exp_resp);
      check_eq("b_hold_awready", awready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    check_eq("bresp", bresp, exp_resp);
    check_eq("bid", bid, exp_id);
    @(negedge clk);
    bready = 1'b0;
    check_eq("b_done_awready", awready, 1);
  endtask

  task automatic ar_req(input logic id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    for (int n = 0; n < Tmo && !arready; n++) @(negedge clk);
    if (!arready) check_eq("ar_timeout", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    check_eq("ar_latency_rvalid", rvalid, 1);
  endtask

  task automatic r_beat(input logic [31:0] d, input logic l, input logic [1:0] resp,
                        input logic id);
    rready = 1'b1;
    last_wait = 0;
    while (last_wait < Tmo && !rvalid) begin
      @(negedge clk);
      last_wait++;
    end
    if (!rvalid) check_eq("r_timeout", rvalid, 1);
    check_eq("rdata", rdata, d);
    check_eq("rlast", rlast, l);
    check_eq("rresp", rresp, resp);
    check_eq("rid", rid, id);
    @(negedge clk);
    if (l) begin
      rready = 1'b0;
      check_eq("r_end_rvalid", rvalid, 0);
      check_eq("r_end_arready", arready, 1);
    end
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] d);
    aw_req(1'b0, addr, 4'd0, 2'b01);
    w_beat(d, 4'hF, 1'b1);
    b_resp(2'b00, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_awready", awready, 1);
    check_eq("rst_arready", arready, 1);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_bid", bid, 0);
    check_eq("rst_rid", rid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // INCR write LEN=3 then read back back-to-back
    aw_req(1'b1, 32'h8000_0010, 4'd3, 2'b01);
    w_beat(32'h1111_1111, 4'hF, 1'b0);
    w_beat(32'h2222_2222, 4'hF, 1'b0);
    w_beat(32'h3333_3333, 4'hF, 1'b0);
    w_beat(32'h4444_4444, 4'hF, 1'b1);
    b_resp(2'b00, 1'b1, 0);
    ar_req(1'b1, 32'h8000_0010, 4'd3, 2'b01);
    r_beat(32'h1111_1111, 1'b0, 2'b00, 1'b1);
    r_beat(32'h2222_2222, 1'b0, 2'b00, 1'b1);
    check_eq("r_b2b_wait", last_wait, 0);
    r_beat(32'h3333_3333, 1'b0, 2'b00, 1'b1);
    check_eq("r_b2b_wait", last_wait, 0);
    r_beat(32'h4444_4444, 1'b1, 2'b00, 1'b1);
    check_eq("r_b2b_wait", last_wait, 0);

    // Byte strobes; W presented before AW must not be taken
    write1(32'h8000_0000, 32'hAABB_CCDD);
    wdata = 32'h1122_3344; wstrb = 4'b0101; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check_eq("w_before_aw_wready", wready, 0);
    aw_req(1'b0, 32'h8000_0000, 4'd0, 2'b01);
    w_beat(32'h1122_3344, 4'b0101, 1'b1);
    b_resp(2'b00, 1'b0, 0);
    ar_req(1'b0, 32'h8000_0000, 4'd0, 2'b01);
    r_beat(32'hAA22_CC44, 1'b1, 2'b00, 1'b0);

    // FIXED read with RREADY stall
    write1(32'h8000_0004, 32'hDEAD_BEEF);
    ar_req(1'b1, 32'h8000_0004, 4'd2, 2'b00);
    r_beat(32'hDEAD_BEEF, 1'b0, 2'b00, 1'b1);
    rready = 1'b0;
    repeat (2) begin
      check_eq("stall_rvalid", rvalid, 1);
      check_eq("stall_rdata", rdata, 32'hDEAD_BEEF);
      check_eq("stall_rlast", rlast, 0);
      @(negedge clk);
    end
    r_beat(32'hDEAD_BEEF, 1'b0, 2'b00, 1'b1);
    r_beat(32'hDEAD_BEEF, 1'b1, 2'b00, 1'b1);

    // Out of range: write dropped (word 0 unchanged), read straddling the top
    aw_req(1'b0, 32'h8000_1000, 4'd0, 2'b01);
    w_beat(32'h1234_5678, 4'hF, 1'b1);
    b_resp(2'b11, 1'b0, 0);
    ar_req(1'b0, 32'h8000_0000, 4'd0, 2'b01);
    r_beat(32'hAA22_CC44, 1'b1, 2'b00, 1'b0);
    write1(32'h8000_0FFC, 32'hCAFE_F00D);
    ar_req(1'b0, 32'h8000_0FFC, 4'd1, 2'b01);
    r_beat(32'hCAFE_F00D, 1'b0, 2'b00, 1'b0);
    r_beat(32'h0000_0000, 1'b1, 2'b11, 1'b0);

    // Early WLAST: all beats still written, SLVERR, B stalled
    aw_req(1'b1, 32'h8000_0020, 4'd3, 2'b01);
    w_beat(32'hA000_0000, 4'hF, 1'b0);
    w_beat(32'hA111_1111, 4'hF, 1'b1);
    w_beat(32'hA222_2222, 4'hF, 1'b0);
    w_beat(32'hA333_3333, 4'hF, 1'b0);
    b_resp(2'b10, 1'b1, 5);
    ar_req(1'b0, 32'h8000_0020, 4'd3, 2'b01);
    r_beat(32'hA000_0000, 1'b0, 2'b00, 1'b0);
    r_beat(32'hA111_1111, 1'b0, 2'b00, 1'b0);
    r_beat(32'hA222_2222, 1'b0, 2'b00, 1'b0);
    r_beat(32'hA333_3333, 1'b1, 2'b00, 1'b0);

    // Reset during beat 2 of a LEN=7 read
    ar_req(1'b1, 32'h8000_0010, 4'd7, 2'b01);
    r_beat(32'h1111_1111, 1'b0, 2'b00, 1'b1);
    r_beat(32'h2222_2222, 1'b0, 2'b00, 1'b1);
    check_eq("mid_rdata", rdata, 32'h3333_3333);
    rready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_rvalid", rvalid, 0);
    check_eq("mid_rst_rlast", rlast, 0);
    check_eq("mid_rst_arready", arready, 1);
    check_eq("mid_rst_awready", awready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    ar_req(1'b0, 32'h8000_0010, 4'd0, 2'b01);
    r_beat(32'h1111_1111, 1'b1, 2'b00, 1'b0);
    ar_req(1'b0, 32'h8000_0FFC, 4'd0, 2'b00);
    r_beat(32'hCAFE_F00D, 1'b1, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_s_mem.md
Name: axi_s_mem

Overview:
- AXI slave/responder: the other end of the core's AXI master port, so it accepts AW/W/B and AR/R transactions.
- Backs them with an on-chip word memory and serves as boot/data RAM in simulation and FPGA builds.
- Same channel subset as the master side: single ID bit, 4-bit LEN, FIXED/INCR bursts, 32-bit data.
- Read and write paths are independent FSMs sharing one memory.

Parameters:
- WIDTH_ID, 1, ID width (echoed on BID/RID)
- WIDTH_AD, 32, address width
- WIDTH_DA, 32, data width; only 32 is supported
- DEPTH, 1024, memory depth in 32-bit words (power of two)
- BASE_ADDR, 32'h8000_0000, byte address of word 0

Ports:
- S_AXI_ACLK in 1: clock
- S_AXI_ARESETN in 1: reset, synchronous, active-low
- S_AXI_AWID in WIDTH_ID / S_AXI_AWADDR in WIDTH_AD / S_AXI_AWLEN in 4 / S_AXI_AWSIZE in 3 / S_AXI_AWBURST in 2: write address attributes
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address handshake
- S_AXI_WDATA in WIDTH_DA / S_AXI_WSTRB in WIDTH_DA/8 / S_AXI_WLAST in 1: write beat
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data handshake
- S_AXI_BID out WIDTH_ID / S_AXI_BRESP out 2: write response
- S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response handshake
- S_AXI_ARID in WIDTH_ID / S_AXI_ARADDR in WIDTH_AD / S_AXI_ARLEN in 4 / S_AXI_ARSIZE in 3 / S_AXI_ARBURST in 2: read address attributes
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address handshake
- S_AXI_RID out WIDTH_ID / S_AXI_RDATA out WIDTH_DA / S_AXI_RRESP out 2 / S_AXI_RLAST out 1: read beat
- S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data handshake

Behaviour:
- Clocking/reset: one clock S_AXI_ACLK; reset S_AXI_ARESETN, synchronous, active-low.
- Reset values: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP, RDATA, BID, RID = 0. Both FSMs go to Idle.
- Reset mid-burst: the burst is abandoned, and all valids/readies take their reset values at the next edge. Memory contents are preserved.
- Beat counting: a handshake is VALID&READY on a rising edge. Beats per burst = LEN+1 (1..16). SIZE is ignored; every beat is 4 bytes.
- Address step: INCR adds 4 per beat; FIXED keeps the address. WRAP (2'b10) and 2'b11 are treated as INCR.
- Decode: word index = (addr-BASE_ADDR)>>2. A beat is in range if (addr-BASE_ADDR) < DEPTH*4; the range check is done per beat.
- Write FSM W_Idle / W_Data / W_Resp:
  - W_Idle: AWREADY=1. On AW handshake, latch AWID, addr, LEN and BURST, clear the error flags, set AWREADY=0 and WREADY=1, and go to W_Data.
  - W_Data: on each W handshake, write lanes where WSTRB[i]=1 if the beat is in range; out-of-range beats are dropped and set the decerr flag.
  - W_Data, WLAST check: WLAST must equal (beat==LEN); a mismatch sets the slverr flag. The burst always ends on beat LEN regardless of WLAST.
  - W_Data, final beat: WREADY=0, BVALID=1, BRESP = DECERR(11) if decerr, else SLVERR(10) if slverr, else OKAY(00). Go to W_Resp.
  - W_Resp: hold BVALID/BRESP/BID stable until BREADY. On the handshake, BVALID=0 and AWREADY=1, back to W_Idle.
  - Throughput: W handshakes before the AW handshake are not accepted (WREADY=0). The first W beat is accepted at the earliest one cycle after the AW handshake.
- Read FSM R_Idle / R_Data:
  - R_Idle: ARREADY=1. On AR handshake, latch ARID, addr, LEN and BURST, and load RDATA from memory at the first address. Set RVALID=1 the next cycle, RLAST=(LEN==0), ARREADY=0.
  - Latency: AR handshake to first RVALID is exactly 1 cycle.
  - R_Data: RDATA/RRESP/RLAST/RID are held stable while RVALID & !RREADY.
  - R_Data, on handshake with RLAST=0: advance the address, load the next word, and RLAST=(next beat==LEN). Back-to-back beats are supported with no bubbles.
  - R_Data, on handshake with RLAST=1: RVALID=0, RLAST=0, ARREADY=1, back to R_Idle.
  - RRESP is per beat: DECERR with RDATA=0 if out of range, else OKAY.
- Read/write collision: a same-cycle write and read fetch to the same word returns the old data (read-before-write).
- Concurrency: read and write bursts may overlap freely; there is no ordering between the channels.

Decomposition:
- Package axi_pkg:
  - BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - W_Idle/W_Data/W_Resp and R_Idle/R_Data state encodings
  - BYTES_PER_BEAT=4
- Sub-module axi_s_ram: DEPTH x 32 RAM with one byte-enabled write port and one synchronous read port (read-before-write). The top-level FSMs instantiate it.

Test Plan:
- Write then read, INCR LEN=3: AW 0x8000_0010, beats 0x11111111/0x22222222/0x33333333/0x44444444 with WSTRB=F and WLAST on beat 3 -> BRESP=00 with BID=AWID. AR at the same address -> RDATA in that order, RLAST on beat 3 only, RRESP=00, first RVALID 1 cycle after the AR handshake.
- Byte strobes: word 0x8000_0000 preset 0xAABBCCDD; single beat 0x11223344 with WSTRB=4'b0101 -> readback 0xAA22CC44.
- FIXED read LEN=2 at 0x8000_0004 holding 0xDEADBEEF -> three beats of 0xDEADBEEF. RREADY low for 2 cycles mid-burst -> RDATA/RLAST held, no beat lost.
- Out of range: write at BASE_ADDR+DEPTH*4 -> BRESP=11, memory unchanged. INCR read LEN=1 at BASE_ADDR+DEPTH*4-4 -> beat0 OKAY with data, beat1 DECERR with RDATA=0.
- WLAST error: LEN=3 with WLAST asserted on beat 1 -> all 4 beats written, BRESP=10. BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY stays 0.
- Reset mid-burst: deassert ARESETN during beat 2 of a LEN=7 read -> next edge RVALID=0 and ARREADY=1. Previously written data is still readable after reset.
